// File: rtl/core_phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// core_phase_sequencer_pkg
// Shared RockWave core constants: default counter width, the binary state
// encoding of the phase sequencer (visible to decoder / debug logic), and the
// instruction fields latched during DECODE.
// -----------------------------------------------------------------------------
package core_phase_sequencer_pkg;

  localparam int CORE_XLEN = 32;

  // Binary 3-bit state encoding, exported so other blocks can decode it.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_EXECUTE   = ST_EXECUTE,
    S_MEMORY    = ST_MEMORY,
    S_WRITEBACK = ST_WRITEBACK
  } state_e;

  // Instruction fields captured in DECODE and held until the next DECODE.
  typedef struct packed {
    logic [4:0] rd;
    logic       wb_en;
    logic       is_mem;
  } inst_fields_t;

  // A register-file write only happens for an enabled write to a non-x0 rd.
  function automatic logic wb_active(input inst_fields_t f);
    return f.wb_en && (f.rd != 5'd0);
  endfunction

endpackage

// File: rtl/core_phase_sequencer_counter.sv
// -----------------------------------------------------------------------------
// core_counter
// W-bit wrap-around event counter with asynchronous active-high reset.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous reset, clears the count to 0
//   en    in   increment enable (count + 1 on the rising edge)
//   count out  current count; wraps from all-ones to 0 silently
// -----------------------------------------------------------------------------
module core_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/core_phase_sequencer.sv
// -----------------------------------------------------------------------------
// core_phase_sequencer
// Multi-cycle phase sequencer: steps each instruction through FETCH, DECODE,
// EXECUTE, optional MEMORY and WRITEBACK, handshaking with instruction and
// data memory, driving the register-file write strobe / select and keeping
// the active-cycle and retired-instruction counters.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   run                           allow a new instruction to start
//   imem_req / imem_ack           instruction fetch handshake
//   inst_rd, inst_wb_en,
//   inst_is_mem, inst_trap        decoder outputs, sampled in DECODE
//   exec_busy                     multi-cycle execute still running
//   dmem_req / dmem_ack           data access handshake
//   phase_fetch .. phase_memory   one-hot phase indicators
//   phase_writeback, rdsel        register-file write strobe and select
//   cycle_cnt, instret_cnt        active-cycle / retired-instruction counters
// All outputs are Moore: decoded from the state and latched fields only.
// -----------------------------------------------------------------------------
module core_phase_sequencer
  import core_phase_sequencer_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [4:0]      inst_rd,
  input  logic            inst_wb_en,
  input  logic            inst_is_mem,
  input  logic            inst_trap,
  input  logic            exec_busy,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            phase_fetch,
  output logic            phase_decode,
  output logic            phase_execute,
  output logic            phase_memory,
  output logic            phase_writeback,
  output logic [4:0]      rdsel,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  state_e       state_q, state_d;
  inst_fields_t fields_q, fields_d;

  // State and latched-field register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
    end
  end

  // Next-state logic. Acks are only looked at in their own state, so a stray
  // dmem_ack in EXECUTE cannot satisfy the following MEMORY phase.
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        fields_d.rd     = inst_rd;
        fields_d.wb_en  = inst_wb_en;
        fields_d.is_mem = inst_is_mem;
        if (inst_trap) begin
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!exec_busy) state_d = fields_q.is_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (dmem_ack) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    imem_req        = 1'b0;
    dmem_req        = 1'b0;
    phase_fetch     = 1'b0;
    phase_decode    = 1'b0;
    phase_execute   = 1'b0;
    phase_memory    = 1'b0;
    phase_writeback = 1'b0;
    rdsel           = 5'd0;
    case (state_q)
      S_FETCH: begin
        phase_fetch = 1'b1;
        imem_req    = 1'b1;
      end
      S_DECODE:  phase_decode  = 1'b1;
      S_EXECUTE: phase_execute = 1'b1;
      S_MEMORY: begin
        phase_memory = 1'b1;
        dmem_req     = 1'b1;
      end
      S_WRITEBACK: begin
        phase_writeback = wb_active(fields_q);
        rdsel           = wb_active(fields_q) ? fields_q.rd : 5'd0;
      end
      default: ;
    endcase
  end

  // Counter 0 counts active (non-IDLE) cycles, counter 1 counts retirements.
  logic [1:0]      cnt_en;
  logic [XLEN-1:0] cnt_val [2];

  assign cnt_en[0] = (state_q != S_IDLE);
  assign cnt_en[1] = (state_q == S_WRITEBACK);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      core_counter #(.W(XLEN)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign cycle_cnt   = cnt_val[0];
  assign instret_cnt = cnt_val[1];

endmodule

// File: tb/tb_core_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_phase_sequencer
// Randomised scoreboard bench. The generator builds each instruction as a
// timeline of phases (fetch wait, decode, busy cycles, memory wait, writeback)
// and pushes the expected output vector of every cycle into a queue; the
// monitor pops one entry per cycle on the falling edge and compares. The DUT
// uses an 8-bit counter width so both counters wrap during the random run.
// -----------------------------------------------------------------------------
module tb_core_phase_sequencer;

  localparam int XL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          imem_req;
  logic          imem_ack = 1'b0;
  logic [4:0]    inst_rd = 5'd0;
  logic          inst_wb_en = 1'b0;
  logic          inst_is_mem = 1'b0;
  logic          inst_trap = 1'b0;
  logic          exec_busy = 1'b0;
  logic          dmem_req;
  logic          dmem_ack = 1'b0;
  logic          phase_fetch, phase_decode, phase_execute, phase_memory;
  logic          phase_writeback;
  logic [4:0]    rdsel;
  logic [XL-1:0] cycle_cnt, instret_cnt;

  core_phase_sequencer #(.XLEN(XL)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .inst_rd         (inst_rd),
    .inst_wb_en      (inst_wb_en),
    .inst_is_mem     (inst_is_mem),
    .inst_trap       (inst_trap),
    .exec_busy       (exec_busy),
    .dmem_req        (dmem_req),
    .dmem_ack        (dmem_ack),
    .phase_fetch     (phase_fetch),
    .phase_decode    (phase_decode),
    .phase_execute   (phase_execute),
    .phase_memory    (phase_memory),
    .phase_writeback (phase_writeback),
    .rdsel           (rdsel),
    .cycle_cnt       (cycle_cnt),
    .instret_cnt     (instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          f, d, e, m, w, ireq, dreq;
    logic [4:0]    rdsel;
    logic [XL-1:0] cyc, ret;
  } exp_t;

  // Phase codes used by the generator.
  localparam int P_IDLE = 0, P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_m  = 0;   // active cycles seen so far (reference model)
  int   ret_m  = 0;   // instructions retired so far (reference model)

  // Expected outputs for one cycle in phase ph; wrd is the write-back rd
  // (already 0 when the write is suppressed).
  function automatic exp_t mk(input int ph, input logic [4:0] wrd);
    exp_t e;
    e = '0;
    case (ph)
      P_F: begin e.f = 1'b1; e.ireq = 1'b1; end
      P_D: e.d = 1'b1;
      P_E: e.e = 1'b1;
      P_M: begin e.m = 1'b1; e.dreq = 1'b1; end
      P_W: begin e.rdsel = wrd; e.w = (wrd != 5'd0); end
      default: ;
    endcase
    e.cyc = XL'(cyc_m);
    e.ret = XL'(ret_m);
    return e;
  endfunction

  // Randomise every input; callers then override the ones that matter.
  task automatic noise();
    run         = 1'($urandom);
    imem_ack    = 1'($urandom);
    dmem_ack    = 1'($urandom);
    exec_busy   = 1'($urandom);
    inst_rd     = 5'($urandom);
    inst_wb_en  = 1'($urandom);
    inst_is_mem = 1'($urandom);
    inst_trap   = 1'($urandom);
  endtask

  // Publish this cycle's expectation, then advance one clock.
  task automatic tick(input exp_t e, input bit active, input bit retire);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (active) cyc_m++;
    if (retire) ret_m++;
  endtask

  // n IDLE cycles; run is raised only in the last one so FETCH follows.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      run = (i == n - 1);
      tick(mk(P_IDLE, 5'd0), 1'b0, 1'b0);
    end
  endtask

  int n_tx = 0;

  task automatic instr(input logic [4:0] rd, input logic wb, input logic mem,
                       input logic trap, input int fw, input int eb,
                       input int mw, input logic run_end);
    logic [4:0] wrd;
    $display("tx %0d: rd=%0d wb=%0b mem=%0b trap=%0b fwait=%0d busy=%0d mwait=%0d run_end=%0b",
             n_tx, rd, wb, mem, trap, fw, eb, mw, run_end);
    n_tx++;
    for (int i = 0; i <= fw; i++) begin
      noise();
      imem_ack = (i == fw);
      tick(mk(P_F, 5'd0), 1'b1, 1'b0);
    end
    noise();
    inst_rd = rd; inst_wb_en = wb; inst_is_mem = mem; inst_trap = trap;
    if (trap) run = run_end;
    tick(mk(P_D, 5'd0), 1'b1, 1'b0);
    if (trap) return;
    for (int i = 0; i <= eb; i++) begin
      noise();
      exec_busy = (i < eb);
      tick(mk(P_E, 5'd0), 1'b1, 1'b0);
    end
    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        noise();
        dmem_ack = (i == mw);
        tick(mk(P_M, 5'd0), 1'b1, 1'b0);
      end
    end
    wrd = (wb && rd != 5'd0) ? rd : 5'd0;
    noise();
    run = run_end;
    tick(mk(P_W, wrd), 1'b1, 1'b1);
  endtask

  // Enter MEMORY with no ack, then assert reset inside the next cycle.
  task automatic reset_in_memory();
    $display("tx %0d: reset asserted during MEMORY", n_tx);
    n_tx++;
    noise(); imem_ack = 1'b1;
    tick(mk(P_F, 5'd0), 1'b1, 1'b0);
    noise(); inst_is_mem = 1'b1; inst_trap = 1'b0;
    tick(mk(P_D, 5'd0), 1'b1, 1'b0);
    noise(); exec_busy = 1'b0;
    tick(mk(P_E, 5'd0), 1'b1, 1'b0);
    noise(); dmem_ack = 1'b0;
    tick(mk(P_M, 5'd0), 1'b1, 1'b0);
    noise(); dmem_ack = 1'b0;
    rst   = 1'b1;
    cyc_m = 0;
    ret_m = 0;
    tick(mk(P_IDLE, 5'd0), 1'b0, 1'b0);
    noise();
    tick(mk(P_IDLE, 5'd0), 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);
  endtask

  // Monitor: one comparison per cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {phase_fetch, phase_decode, phase_execute, phase_memory,
           phase_writeback, imem_req, dmem_req, rdsel, cycle_cnt, instret_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got f%b d%b e%b m%b w%b ireq%b dreq%b rdsel=%0d cyc=%0d ret=%0d required f%b d%b e%b m%b w%b ireq%b dreq%b rdsel=%0d cyc=%0d ret=%0d",
                 $time, g.f, g.d, g.e, g.m, g.w, g.ireq, g.dreq, g.rdsel, g.cyc, g.ret,
                 e.f, e.d, e.e, e.m, e.w, e.ireq, e.dreq, e.rdsel, e.cyc, e.ret);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Held in reset: everything at reset values.
    tick(mk(P_IDLE, 5'd0), 1'b0, 1'b0);
    tick(mk(P_IDLE, 5'd0), 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);

    // Plain ALU op, rd=5, zero-wait fetch.
    instr(5'd5, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    // Load to x0 with busy execute and memory wait states.
    instr(5'd0, 1'b1, 1'b1, 1'b0, 0, 2, 3, 1'b1);
    // Trapping instruction goes straight back to FETCH.
    instr(5'd7, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1);
    // Write disabled with non-zero rd.
    instr(5'd12, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1);
    // run low at the end: retire then IDLE, counters freeze.
    instr(5'd9, 1'b1, 1'b0, 1'b0, 1, 2, 0, 1'b0);
    idle(3);
    reset_in_memory();

    // Random traffic long enough for both 8-bit counters to wrap.
    for (int n = 0; n < 420; n++) begin
      logic run_end;
      run_end = ($urandom_range(0, 3) != 0);
      instr(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 3), run_end);
      if (!run_end) idle($urandom_range(1, 3));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    checks++;
    if (ret_m < 256 || cyc_m < 256) begin
      errors++;
      $display("FAIL wrap_coverage: got ret=%0d cyc=%0d, required both >= 256", ret_m, cyc_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
